// File: rtl/inpass_config_sequencer.sv
// Shadow/active configuration banks for InPass BELs: frames are staged in the
// shadow bank and copied to the active bank in one edge after a settle interval.
module inpass_config_sequencer #(
   parameter int unsigned NUM_BELS      = 4,
   parameter int unsigned BITS_PER_BEL  = 4,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned ADDR_W        = 4
) (
   input  logic                             UserCLK,
   input  logic                             RST,
   input  logic                             cfg_valid,
   output logic                             cfg_ready,
   input  logic [ADDR_W-1:0]                cfg_addr,
   input  logic [BITS_PER_BEL-1:0]          cfg_data,
   input  logic                             cfg_last,
   input  logic                             cfg_abort,
   output logic [NUM_BELS*BITS_PER_BEL-1:0] ConfigBits_out,
   output logic                             commit_done,
   output logic                             busy,
   output logic                             err
);

   localparam int unsigned BANK_W = NUM_BELS * BITS_PER_BEL;
   localparam int unsigned CNT_W  = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_COMMIT
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [BANK_W-1:0]  shadow;
   logic               ready_q;
   logic               accept;
   logic               in_range;
   logic               abort_take;
   logic               open_state;
   logic               busy_nxt;
   logic               done_nxt;

   // Abort blocks the handshake in the same cycle it is presented.
   assign cfg_ready  = ready_q && !cfg_abort;
   assign accept     = cfg_valid && cfg_ready;
   assign in_range   = 32'(cfg_addr) < NUM_BELS;
   assign open_state = (state == S_IDLE) || (state == S_LOAD);
   assign abort_take = cfg_abort && open_state;

   always_ff @(posedge UserCLK) begin
      if (RST) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      case (state)
         S_IDLE, S_LOAD: begin
            if (abort_take) begin
               state_nxt = S_IDLE;
            end else if (accept) begin
               if (!cfg_last) begin
                  state_nxt = S_LOAD;
               end else if (SETTLE_CYCLES == 0) begin
                  state_nxt = S_COMMIT;
               end else begin
                  state_nxt = S_SETTLE;
                  cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
               end
            end
         end
         S_SETTLE: begin
            if (cnt == '0) begin
               state_nxt = S_COMMIT;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_COMMIT: begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
      busy_nxt = (state_nxt == S_SETTLE) || (state_nxt == S_COMMIT);
   end

   // Banks, status flags and registered handshake outputs.
   always_ff @(posedge UserCLK) begin
      if (RST) begin
         shadow         <= '0;
         ConfigBits_out <= '0;
         ready_q        <= 1'b1;
         busy           <= 1'b0;
         commit_done    <= 1'b0;
         err            <= 1'b0;
      end else begin
         ready_q     <= !busy_nxt;
         busy        <= busy_nxt;
         commit_done <= done_nxt;
         if (abort_take) begin
            shadow <= ConfigBits_out;
         end else if (accept && in_range) begin
            for (int i = 0; i < int'(NUM_BELS); i++) begin
               if (32'(cfg_addr) == 32'(i)) begin
                  shadow[i*BITS_PER_BEL +: BITS_PER_BEL] <= cfg_data;
               end
            end
         end
         if (accept && !in_range) begin
            err <= 1'b1;
         end
         if (state == S_COMMIT) begin
            ConfigBits_out <= shadow;
         end
      end
   end

endmodule
